// File: rtl/encode_4x2_reg.sv
// encode_4x2_reg: registered 4-to-2 priority encoder with a valid/ready
// output handshake, a multi-hot flag, a sticky multi-hot error and a
// saturating count of completed handshakes.
//
// Handshake: the block offers a code while V=1. The code, M and V stay
// stable until the consumer raises R. A handshake completes on any rising
// edge where V=1 and R=1. On that same edge a new request, if present, is
// captured, so one code per clock can stream. R is ignored while V=0.
module encode_4x2_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic             R,
  input  logic             CLR,
  output logic             A,
  output logic             B,
  output logic             V,
  output logic             M,
  output logic             ERR,
  output logic [CNT_W-1:0] CNT,
  output logic             dbg_hold
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             m_q, m_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       req;
  logic       multi;
  logic [2:0] hot_cnt;
  logic [1:0] code;
  logic       handshake;
  logic       capture;

  // Decode the request lines: presence, priority code and multi-hot flag.
  always_comb begin
    req     = E & (d0 | d1 | d2 | d3);
    hot_cnt = {2'b00, d0} + {2'b00, d1} + {2'b00, d2} + {2'b00, d3};
    multi   = (hot_cnt > 3'd1);
    if (d3)      code = 2'b11;
    else if (d2) code = 2'b10;
    else if (d1) code = 2'b01;
    else         code = 2'b00;
  end

  // Next-state logic for the FSM, held code, error flag and counter.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    handshake = (state_q == HOLD) & R;
    capture   = req & ((state_q == IDLE) | R);

    case (state_q)
      IDLE: begin
        if (req) state_d = HOLD;
      end
      HOLD: begin
        if (R && !req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      b_d = code[1];
      a_d = code[0];
      m_d = multi;
    end

    if (CLR) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (capture && multi)                  err_d = 1'b1;
      if (handshake && (cnt_q != CNT_MAX))   cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; reset discards any pending code without counting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      m_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from flops; V is the HOLD state itself.
  always_comb begin
    A        = a_q;
    B        = b_q;
    M        = m_q;
    ERR      = err_q;
    CNT      = cnt_q;
    V        = (state_q == HOLD);
    dbg_hold = (state_q == HOLD);
  end

endmodule

// File: doc/encode_4x2_reg.md
ENCODE_4X2_REG -- requirements
Module: encode_4X2_reg

Interface
REQ-001 Parameter: CNT_W, default 8, width of handshake event counter (legal 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 E  input  1  enable; capture permitted only when E=1.
REQ-005 d0, d1, d2, d3  input  1 each  request lines; index n corresponds to decoded line zn of the team's 2x4 decoder.
REQ-006 R  input  1  consumer ready.
REQ-007 CLR  input  1  synchronous clear of ERR and CNT.
REQ-008 A  output  1  code LSB, registered.
REQ-009 B  output  1  code MSB, registered.
REQ-010 V  output  1  code valid, registered.
REQ-011 M  output  1  multi-hot flag for the code currently held, registered.
REQ-012 ERR  output  1  sticky multi-hot error, registered.
REQ-013 CNT  output  CNT_W  count of completed handshakes, registered.

Function
REQ-014 Code mapping SHALL invert the decoder: d0->(B,A)=(0,0), d1->(0,1), d2->(1,0), d3->(1,1).
REQ-015 Priority: highest asserted index wins (d3 > d2 > d1 > d0).
REQ-016 "Request present" SHALL mean E=1 and at least one of d0..d3 =1; all-zero with E=1 is not a request.
REQ-017 FSM states: IDLE (V=0), HOLD (V=1); no other states.
REQ-018 IDLE, request present at edge: load A/B per REQ-014/015, load M, set V=1, go HOLD; latency exactly 1 clock from sampled inputs to V=1.
REQ-019 IDLE, no request: stay IDLE; A, B, M retain last values.
REQ-020 HOLD, R=0: A, B, M, V held stable; d0..d3 and E ignored (no overwrite, no queuing).
REQ-021 HOLD, R=1 at edge: handshake complete; CNT increments.
REQ-022 HOLD, R=1 and request present same edge: load new code/M, stay HOLD, V stays 1 (back-to-back, one code per clock max).
REQ-023 HOLD, R=1, no request: go IDLE, V=0 next cycle.
REQ-024 E deasserted during HOLD SHALL NOT drop V or alter held code.
REQ-025 M=1 when more than one d line asserted at capture, else 0.
REQ-026 ERR set on any capture with M condition; stays set until CLR or reset.
REQ-027 CNT saturates at 2^CNT_W-1; no wrap.
REQ-028 CLR=1 at edge: ERR=0, CNT=0; CLR wins over coincident increment and coincident ERR set; CLR does not affect FSM, A, B, M, V.
REQ-029 R in IDLE ignored; no count.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, A=0, B=0, V=0, M=0, ERR=0, CNT=0, including mid-HOLD (pending code discarded, not counted).
REQ-031 First capture possible on first rising edge after rst_n deasserts with request present.

Verification
REQ-032 Single hot: E=1, d2=1, R=0 -> next cycle V=1, B=1, A=0, M=0; held while R=0 for 5 cycles with inputs changed to d1.
REQ-033 Multi-hot: E=1, d0=d1=d3=1 -> (B,A)=(1,1), M=1, ERR=1; after accept with clean d1 request M=0, ERR stays 1; CLR -> ERR=0, CNT=0.
REQ-034 Back-to-back: R=1 constantly, requests d3, d0, d1 on three consecutive edges -> V=1 throughout, codes 11, 00, 01, CNT=3; then E=0 -> V=0 after next handshake.
REQ-035 Saturation: CNT_W=2, 5 handshakes -> CNT=3; CLR with concurrent handshake -> CNT=0.
REQ-036 Reset mid-HOLD: V=1 code 10, assert rst_n=0 between edges -> outputs zero immediately, CNT unchanged from 0-reset value, IDLE after release.
REQ-037 Enable gating: E=0, d3=1 for 4 cycles -> V stays 0; E=0 all-zero plus R=1 -> CNT unchanged.
